// File: rtl/fp_div_seq_pkg.sv
// Shared FP32 special values, divider state encoding and small helpers.
package fp_div_seq_pkg;

    // Number of quotient bits produced: 1 integer + 23 fraction + guard + 2 extra.
    localparam int ITER = 27;

    // Iteration counter value of the last restoring step.
    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    // Special FP32 encodings; signed variants are built from these.
    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam logic [31:0] FP_PZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        RND  = 2'd3
    } fp_div_state_t;

    // Infinity carrying the requested sign.
    function automatic logic [31:0] fp_signed_inf(input logic sign);
        return FP_PINF | {sign, 31'd0};
    endfunction

    // Zero carrying the requested sign.
    function automatic logic [31:0] fp_signed_zero(input logic sign);
        return FP_PZERO | {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp_div_seq_classify.sv
// Combinational FP32 operand classifier (flush-to-zero: exponent 0 counts as zero).
module fp_classify (
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        sign
);

    logic [7:0]  exp_s;
    logic [22:0] frac_s;

    assign exp_s  = op[30:23];
    assign frac_s = op[22:0];

    // Decode the operand class from exponent and fraction fields
    always_comb begin
        sign    = op[31];
        is_zero = (exp_s == 8'd0);
        is_inf  = (exp_s == 8'hFF) && (frac_s == 23'd0);
        is_nan  = (exp_s == 8'hFF) && (frac_s != 23'd0);
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative FP32 divider Y = A / B: one restoring quotient bit per clock,
// then a normalise cycle and a round-to-nearest-even cycle. Specials finish
// in the accept cycle. Subnormal inputs and results are flushed to zero.
module fp_div_seq
    import fp_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Y,
    output logic        NV,
    output logic        DZ,
    output logic        OF,
    output logic        UF
);

    fp_div_state_t state_r, state_next_s;

    // Operand classification
    logic a_zero_s, a_inf_s, a_nan_s, a_sign_s;
    logic b_zero_s, b_inf_s, b_nan_s, b_sign_s;
    logic accept_s, special_s;
    logic [31:0] spec_y_s;
    logic spec_nv_s, spec_dz_s;

    // Iteration datapath state
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mb_r;
    logic [24:0]        rem_r;
    logic [26:0]        q_r;
    logic [4:0]         cnt_r;
    logic [23:0]        mant_r;
    logic               guard_r;
    logic               sticky_r;

    // Combinational step / normalise / round values
    logic               rem_ge_s;
    logic [23:0]        rem_sub_s;
    logic [26:0]        q_norm_s;
    logic signed [9:0]  exp_norm_s;
    logic               round_up_s;
    logic [24:0]        mant_sum_s;
    logic [22:0]        mant_rnd_s;
    logic signed [9:0]  exp_rnd_s;
    logic [31:0]        rnd_y_s;
    logic               rnd_of_s, rnd_uf_s;

    // Registered outputs
    logic        busy_r, done_r;
    logic [31:0] y_r;
    logic        nv_r, dz_r, of_r, uf_r;

    fp_classify u_class_a (
        .op      (A),
        .is_zero (a_zero_s),
        .is_inf  (a_inf_s),
        .is_nan  (a_nan_s),
        .sign    (a_sign_s)
    );

    fp_classify u_class_b (
        .op      (B),
        .is_zero (b_zero_s),
        .is_inf  (b_inf_s),
        .is_nan  (b_nan_s),
        .sign    (b_sign_s)
    );

    assign accept_s  = (state_r == IDLE) && start;
    assign special_s = a_zero_s | a_inf_s | a_nan_s | b_zero_s | b_inf_s | b_nan_s;

    // Result and flags for operands that bypass the iteration
    always_comb begin
        spec_y_s  = FP_PZERO;
        spec_nv_s = 1'b0;
        spec_dz_s = 1'b0;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_y_s  = FP_QNAN;
            spec_nv_s = 1'b1;
        end else if (a_inf_s) begin
            // B is finite here, zero included: INF / finite is a plain INF
            spec_y_s = fp_signed_inf(a_sign_s ^ b_sign_s);
        end else if (b_zero_s) begin
            // A is finite and nonzero here
            spec_y_s  = fp_signed_inf(a_sign_s ^ b_sign_s);
            spec_dz_s = 1'b1;
        end else begin
            // 0 / nonzero or finite / INF
            spec_y_s = fp_signed_zero(a_sign_s ^ b_sign_s);
        end
    end

    // Next-state logic for the IDLE -> DIV -> NORM -> RND sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !special_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = NORM;
                end else begin
                    state_next_s = DIV;
                end
            end
            NORM:    state_next_s = RND;
            RND:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // One restoring-division step on the current partial remainder
    always_comb begin
        rem_ge_s = (rem_r >= {1'b0, mb_r});
        if (rem_ge_s) begin
            rem_sub_s = 24'(rem_r - {1'b0, mb_r});
        end else begin
            rem_sub_s = rem_r[23:0];
        end
    end

    // Bring the quotient MSB to bit 26 when the mantissa ratio was below 1
    always_comb begin
        if (q_r[26]) begin
            q_norm_s   = q_r;
            exp_norm_s = exp_r;
        end else begin
            q_norm_s   = {q_r[25:0], 1'b0};
            exp_norm_s = exp_r - 10'sd1;
        end
    end

    // Round to nearest even, then range-check the final exponent
    always_comb begin
        round_up_s = guard_r & (sticky_r | mant_r[0]);
        mant_sum_s = {1'b0, mant_r} + {24'd0, round_up_s};
        if (mant_sum_s[24]) begin
            mant_rnd_s = mant_sum_s[23:1];
            exp_rnd_s  = exp_r + 10'sd1;
        end else begin
            mant_rnd_s = mant_sum_s[22:0];
            exp_rnd_s  = exp_r;
        end
        rnd_of_s = 1'b0;
        rnd_uf_s = 1'b0;
        if (exp_rnd_s >= 10'sd255) begin
            rnd_y_s  = fp_signed_inf(sign_r);
            rnd_of_s = 1'b1;
        end else if (exp_rnd_s <= 10'sd0) begin
            rnd_y_s  = fp_signed_zero(sign_r);
            rnd_uf_s = 1'b1;
        end else begin
            rnd_y_s = {sign_r, exp_rnd_s[7:0], mant_rnd_s};
        end
    end

    // Iteration datapath: operand latch, quotient bits, normalisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            exp_r    <= 10'sd0;
            mb_r     <= 24'd0;
            rem_r    <= 25'd0;
            q_r      <= 27'd0;
            cnt_r    <= 5'd0;
            mant_r   <= 24'd0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !special_s) begin
                        sign_r <= A[31] ^ B[31];
                        exp_r  <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
                        mb_r   <= {1'b1, B[22:0]};
                        rem_r  <= {2'b01, A[22:0]};
                        q_r    <= 27'd0;
                        cnt_r  <= 5'd0;
                    end else begin
                        cnt_r <= 5'd0;
                    end
                end
                DIV: begin
                    rem_r <= {rem_sub_s, 1'b0};
                    q_r   <= {q_r[25:0], rem_ge_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                NORM: begin
                    exp_r    <= exp_norm_s;
                    mant_r   <= q_norm_s[26:3];
                    guard_r  <= q_norm_s[2];
                    sticky_r <= (|q_norm_s[1:0]) | (rem_r != 25'd0);
                end
                RND: begin
                    cnt_r <= 5'd0;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Result register, flags and the one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            y_r    <= 32'h0000_0000;
            nv_r   <= 1'b0;
            dz_r   <= 1'b0;
            of_r   <= 1'b0;
            uf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                of_r <= 1'b0;
                uf_r <= 1'b0;
                if (special_s) begin
                    y_r    <= spec_y_s;
                    nv_r   <= spec_nv_s;
                    dz_r   <= spec_dz_s;
                    done_r <= 1'b1;
                end else begin
                    nv_r <= 1'b0;
                    dz_r <= 1'b0;
                end
            end else if (state_r == RND) begin
                y_r    <= rnd_y_s;
                nv_r   <= 1'b0;
                dz_r   <= 1'b0;
                of_r   <= rnd_of_s;
                uf_r   <= rnd_uf_s;
                done_r <= 1'b1;
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Y    = y_r;
    assign NV   = nv_r;
    assign DZ   = dz_r;
    assign OF   = of_r;
    assign UF   = uf_r;

endmodule
